// File: rtl/canvas_buffer.sv
// Paint canvas: dual-port colour-index RAM with a pipelined circular brush and a
// full-canvas clear sweep on port A, and a palette-mapped video read on port B.
module canvas_buffer #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 360,
  parameter int COLOR_W     = 4,
  parameter int SIZE_W      = 3,
  parameter int RADIUS_STEP = 2,
  parameter int CLEAR_COLOR = 0
) (
  input  logic               pixel_clk_in,
  input  logic               rst_n_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [10:0]        x_in,
  input  logic [9:0]         y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic [SIZE_W-1:0]  size_in,
  input  logic               draw_in,
  input  logic               clear_in,
  output logic               busy_out,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out
);

  localparam int DEPTH  = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int R_W    = 12;
  localparam int R2_W   = 2 * R_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic [23:0] palette(input logic [COLOR_W-1:0] idx);
    logic [23:0] rgb;
    case (int'(idx))
      0:       rgb = 24'h000000;
      1:       rgb = 24'hFFFFFF;
      2:       rgb = 24'hFF0000;
      3:       rgb = 24'h00FF00;
      4:       rgb = 24'h0000FF;
      5:       rgb = 24'hFFFF00;
      6:       rgb = 24'h00FFFF;
      7:       rgb = 24'hFF00FF;
      default: rgb = 24'hFFFFFF;
    endcase
    return rgb;
  endfunction

  // Out-of-range scan points get address 0 so both RAM ports stay inside the array.
  logic              in_range;
  logic [ADDR_W-1:0] scan_addr;

  always_comb begin
    in_range  = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
    scan_addr = '0;
    if (in_range) begin
      scan_addr = ADDR_W'(hcount_in) + ADDR_W'(H_ACTIVE) * ADDR_W'(vcount_in);
    end
  end

  logic signed [11:0]  dx_d, dx_q, dy_d, dy_q;
  logic [ADDR_W-1:0]   s1_addr_d, s1_addr_q;
  logic [COLOR_W-1:0]  s1_color_d, s1_color_q;
  logic                s1_draw_d, s1_draw_q;
  logic [R_W-1:0]      s1_radius_d, s1_radius_q;

  always_comb begin
    dx_d        = $signed({1'b0, hcount_in}) - $signed({1'b0, x_in});
    dy_d        = $signed({2'b00, vcount_in}) - $signed({2'b00, y_in});
    s1_addr_d   = scan_addr;
    s1_color_d  = color_in;
    s1_draw_d   = draw_in && in_range;
    s1_radius_d = R_W'((int'(size_in) + 1) * RADIUS_STEP);
  end

  logic [10:0]         dx_abs, dy_abs;
  logic [21:0]         dx2_d, dx2_q, dy2_d, dy2_q;
  logic [ADDR_W-1:0]   s2_addr_d, s2_addr_q;
  logic [COLOR_W-1:0]  s2_color_d, s2_color_q;
  logic                s2_draw_d, s2_draw_q;
  logic [R2_W-1:0]     s2_r2_d, s2_r2_q;

  // Squaring the magnitude keeps the multipliers unsigned.
  always_comb begin
    dx_abs     = dx_q[11] ? 11'(-dx_q) : dx_q[10:0];
    dy_abs     = dy_q[11] ? 11'(-dy_q) : dy_q[10:0];
    dx2_d      = 22'(dx_abs) * 22'(dx_abs);
    dy2_d      = 22'(dy_abs) * 22'(dy_abs);
    s2_addr_d  = s1_addr_q;
    s2_color_d = s1_color_q;
    s2_draw_d  = s1_draw_q;
    s2_r2_d    = R2_W'(s1_radius_q) * R2_W'(s1_radius_q);
  end

  state_t              state_d, state_q;
  logic [ADDR_W-1:0]   clear_addr_d, clear_addr_q;
  logic [22:0]         dist2;
  logic                brush_hit;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [COLOR_W-1:0]  ram_wdata;

  // Brush writes only land in IDLE, so anything in flight when a sweep starts is dropped.
  always_comb begin
    dist2        = 23'(dx2_q) + 23'(dy2_q);
    brush_hit    = s2_draw_q && (R2_W'(dist2) <= s2_r2_q);
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    ram_we       = 1'b0;
    ram_waddr    = s2_addr_q;
    ram_wdata    = s2_color_q;
    case (state_q)
      IDLE: begin
        ram_we = brush_hit;
        if (clear_in) begin
          state_d      = CLEAR;
          clear_addr_d = '0;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clear_addr_q;
        ram_wdata = COLOR_W'(CLEAR_COLOR);
        if (clear_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [ADDR_W-1:0]  rd_addr_d, rd_addr_q;
  logic               rd_valid_d, rd_valid_q;
  logic               rd_valid2_d, rd_valid2_q;
  logic [COLOR_W-1:0] ram_rdata_q;
  logic [23:0]        rgb_d, rgb_q;

  always_comb begin
    rd_addr_d   = scan_addr;
    rd_valid_d  = in_range;
    rd_valid2_d = rd_valid_q;
    rgb_d       = rd_valid2_q ? palette(ram_rdata_q) : 24'h000000;
  end

  // Block RAM: no reset, read-first on a same-address collision.
  logic [COLOR_W-1:0] mem [DEPTH];

  always_ff @(posedge pixel_clk_in) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata_q <= mem[rd_addr_q];
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dx_q         <= '0;
      dy_q         <= '0;
      s1_addr_q    <= '0;
      s1_color_q   <= '0;
      s1_draw_q    <= 1'b0;
      s1_radius_q  <= '0;
      dx2_q        <= '0;
      dy2_q        <= '0;
      s2_addr_q    <= '0;
      s2_color_q   <= '0;
      s2_draw_q    <= 1'b0;
      s2_r2_q      <= '0;
      state_q      <= IDLE;
      clear_addr_q <= '0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_valid2_q  <= 1'b0;
      rgb_q        <= '0;
    end else begin
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      s1_addr_q    <= s1_addr_d;
      s1_color_q   <= s1_color_d;
      s1_draw_q    <= s1_draw_d;
      s1_radius_q  <= s1_radius_d;
      dx2_q        <= dx2_d;
      dy2_q        <= dy2_d;
      s2_addr_q    <= s2_addr_d;
      s2_color_q   <= s2_color_d;
      s2_draw_q    <= s2_draw_d;
      s2_r2_q      <= s2_r2_d;
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_valid2_q  <= rd_valid2_d;
      rgb_q        <= rgb_d;
    end
  end

  assign busy_out  = (state_q == CLEAR);
  assign red_out   = rgb_q[23:16];
  assign green_out = rgb_q[15:8];
  assign blue_out  = rgb_q[7:0];

endmodule

// File: tb/tb_canvas_buffer.sv
// Scoreboarded bench for canvas_buffer on a reduced 32x24 canvas: raster scans with
// random brushes against an array model of the canvas, plus clear and reset scenarios.
module tb_canvas_buffer;

  localparam int H     = 32;
  localparam int V     = 24;
  localparam int CW    = 4;
  localparam int SW    = 3;
  localparam int RS    = 2;
  localparam int CC    = 0;
  localparam int DEPTH = H * V;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [10:0]   hcount = '0;
  logic [9:0]    vcount = '0;
  logic [10:0]   x = '0;
  logic [9:0]    y = '0;
  logic [CW-1:0] color = '0;
  logic [SW-1:0] size = '0;
  logic          draw = 1'b0;
  logic          clear = 1'b0;
  logic          busy;
  logic [7:0]    red, green, blue;

  canvas_buffer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(CW), .SIZE_W(SW),
    .RADIUS_STEP(RS), .CLEAR_COLOR(CC)
  ) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(hcount), .vcount_in(vcount),
    .x_in(x), .y_in(y), .color_in(color), .size_in(size),
    .draw_in(draw), .clear_in(clear),
    .busy_out(busy), .red_out(red), .green_out(green), .blue_out(blue)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference canvas: colour per pixel plus whether that colour is known.
  logic [CW-1:0] model [DEPTH];
  bit            known [DEPTH];
  bit            clearing = 1'b0;

  int fix_x, fix_y, fix_c, fix_s;

  typedef struct {
    int          due;
    bit          chk;
    logic [23:0] rgb;
    int          h;
    int          v;
  } exp_t;

  exp_t sb[$];

  function automatic logic [23:0] palette(int idx);
    case (idx)
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      2:       return 24'hFF0000;
      3:       return 24'h00FF00;
      4:       return 24'h0000FF;
      5:       return 24'hFFFF00;
      6:       return 24'h00FFFF;
      7:       return 24'hFF00FF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic bit in_brush(int h, int v, int bx, int by, int bs);
    int dx = h - bx;
    int dy = v - by;
    int r  = (bs + 1) * RS;
    return (dx * dx + dy * dy) <= (r * r);
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: rgb for a scan point is due three clocks after it is driven.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        checkOutput($sformatf("schedule h=%0d v=%0d", e.h, e.v), 32'(cyc), 32'(e.due));
      end else if (e.chk) begin
        checkOutput($sformatf("rgb h=%0d v=%0d", e.h, e.v), {8'h00, red, green, blue}, {8'h00, e.rgb});
      end
    end
  end

  // A frame visits each address once, so a pixel's read sees the canvas before its own write.
  task automatic applyStimulus(int h, int v, int bx, int by, int bc, int bs, bit bd, bit bclr);
    exp_t e;
    int   a;
    @(posedge clk);
    #1;
    hcount = 11'(h);
    vcount = 10'(v);
    x      = 11'(bx);
    y      = 10'(by);
    color  = CW'(bc);
    size   = SW'(bs);
    draw   = bd;
    clear  = bclr;
    e.due  = cyc + 3;
    e.h    = h;
    e.v    = v;
    e.rgb  = 24'h000000;
    e.chk  = 1'b1;
    if (h < H && v < V) begin
      a     = h + H * v;
      e.chk = known[a] && !clearing;
      e.rgb = palette(int'(model[a]));
      if (bd && !clearing && in_brush(h, v, bx, by, bs)) begin
        model[a] = CW'(bc);
        known[a] = 1'b1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(H + 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // mode 0: random brush, pen up; 1: fixed brush, pen down; 2: random brush changing every 8 pixels
  task automatic scanFrame(int mode);
    int bx = 0, by = 0, bc = 0, bs = 0;
    bit bd = 1'b0;
    for (int v = 0; v < V + 2; v++) begin
      for (int h = 0; h < H + 4; h++) begin
        if ((h % 8) == 0) begin
          bx = $urandom_range(0, H + 8);
          by = $urandom_range(0, V + 6);
          bc = $urandom_range(0, (1 << CW) - 1);
          bs = $urandom_range(0, (1 << SW) - 1);
          bd = (mode == 2) && ($urandom_range(0, 3) != 0);
        end
        if (mode == 1) begin
          bx = fix_x; by = fix_y; bc = fix_c; bs = fix_s; bd = 1'b1;
        end
        applyStimulus(h, v, bx, by, bc, bs, bd, 1'b0);
      end
    end
  endtask

  task automatic runClear(int repulse_at);
    int n = 0;
    bit done = 1'b0;
    applyStimulus(H + 5, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    clearing = 1'b1;
    for (int i = 0; i < DEPTH + 20 && !done; i++) begin
      applyStimulus(i % (H + 4), (i / (H + 4)) % (V + 2), 5, 5, 3, 1, 1'b0, i == repulse_at);
      if (busy) n++;
      else done = 1'b1;
    end
    checkOutput("busy_length", 32'(n), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = CW'(CC);
      known[a] = 1'b1;
    end
    clearing = 1'b0;
  endtask

  task automatic resetMidClear();
    int k = 0;
    applyStimulus(H + 5, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    clearing = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) begin
      applyStimulus(H - 2, V - 2, 5, 5, 3, 1, 1'b0, 1'b0);
      if (busy) k++;
    end
    checkOutput("busy_before_reset", 32'(busy), 32'd1);
    checkOutput("rgb_before_reset", {8'h00, red, green, blue}, 32'h0000FF00);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("busy_async_reset", 32'(busy), 32'd0);
    checkOutput("rgb_async_reset", {8'h00, red, green, blue}, 32'd0);
    // Sweep reached roughly address k-2; a small band around it is left unchecked.
    for (int a = 0; a < DEPTH; a++) begin
      if (a < k - 4) begin
        model[a] = CW'(CC);
        known[a] = 1'b1;
      end else if (a <= k + 2) begin
        known[a] = 1'b0;
      end
    end
    clearing = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);
    checkOutput("busy_after_release", 32'(busy), 32'd0);
  endtask

  initial begin
    int guard = 0;
    for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("busy_in_reset", 32'(busy), 32'd0);
    checkOutput("rgb_in_reset", {8'h00, red, green, blue}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] full clear then black scan");
    runClear(-1);
    scanFrame(0);

    $display("[TB] fixed brush at (10,8) r=2 colour 2");
    fix_x = 10; fix_y = 8; fix_c = 2; fix_s = 0;
    scanFrame(1);
    scanFrame(0);

    $display("[TB] out-of-range brush points");
    applyStimulus(700, 5, 700, 5, 4, 3, 1'b1, 1'b0);
    idle(2);
    applyStimulus(5, 400, 5, 400, 4, 3, 1'b1, 1'b0);
    idle(3);

    $display("[TB] colour 5 at (10,10) then readback");
    applyStimulus(10, 10, 10, 10, 5, 0, 1'b1, 1'b0);
    idle(3);
    applyStimulus(10, 10, 0, 0, 0, 0, 1'b0, 1'b0);
    idle(3);

    $display("[TB] random brush frames");
    repeat (3) scanFrame(2);
    scanFrame(0);

    $display("[TB] clear with repeated request mid-sweep");
    runClear(DEPTH / 2);
    scanFrame(0);

    $display("[TB] reset during clear");
    scanFrame(2);
    applyStimulus(H - 2, V - 2, H - 2, V - 2, 3, 0, 1'b1, 1'b0);
    idle(3);
    resetMidClear();
    scanFrame(0);

    idle(4);
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
